wb_arbiter: RTL and testbench

- Sole writer of the GPR file's single write port.
- Merges two result sources:
  - primary: the in-order pipeline W stage; fixed timing, cannot stall.
  - secondary: the long-latency mult/div/load result path; valid/ready handshake.
- Secondary results wait in a small FIFO and drain on cycles the primary leaves free.
- Preserves write-after-write ordering per register and exposes per-register pending status to the hazard unit.

---
 rtl/wb_arbiter_pkg.sv | 17 +
 rtl/wb_arbiter_if.sv | 48 ++++
 rtl/wb_fifo.sv | 96 +++++++++
 rtl/wb_arbiter.sv | 72 +++++++
 tb/tb_wb_arbiter.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/wb_arbiter_pkg.sv
// rtl/wb_arbiter_pkg.sv - shared constants and write-record type for the GPR write-back arbiter
package wb_arbiter_pkg;

    localparam int WB_AW    = 5;
    localparam int WB_DW    = 32;
    localparam int WB_DEPTH = 4;

    localparam logic [WB_AW-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic             live;
        logic [WB_AW-1:0] waddr;
        logic [WB_DW-1:0] wdata;
        logic [WB_DW-1:0] pc;
    } wb_rec_t;

endpackage

// File: rtl/wb_arbiter_if.sv
// rtl/wb_arbiter_if.sv - primary/secondary result, GRF write and hazard query signals
interface wb_arbiter_if
    import wb_arbiter_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH,
    parameter int AW    = WB_AW,
    parameter int DW    = WB_DW
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          pri_valid;
    logic [AW-1:0] pri_waddr;
    logic [DW-1:0] pri_wdata;
    logic [DW-1:0] pri_pc;
    logic          sec_valid;
    logic          sec_ready;
    logic [AW-1:0] sec_waddr;
    logic [DW-1:0] sec_wdata;
    logic [DW-1:0] sec_pc;
    logic          grf_we;
    logic [AW-1:0] grf_waddr;
    logic [DW-1:0] grf_wdata;
    logic [DW-1:0] grf_pc;
    logic [AW-1:0] q_addr1;
    logic [AW-1:0] q_addr2;
    logic          q_pending1;
    logic          q_pending2;
    logic [CW-1:0] fifo_count;

    modport slave (
        input  pri_valid, pri_waddr, pri_wdata, pri_pc,
        input  sec_valid, sec_waddr, sec_wdata, sec_pc,
        output sec_ready,
        output grf_we, grf_waddr, grf_wdata, grf_pc,
        input  q_addr1, q_addr2,
        output q_pending1, q_pending2, fifo_count
    );

    modport master (
        output pri_valid, pri_waddr, pri_wdata, pri_pc,
        output sec_valid, sec_waddr, sec_wdata, sec_pc,
        input  sec_ready,
        input  grf_we, grf_waddr, grf_wdata, grf_pc,
        output q_addr1, q_addr2,
        input  q_pending1, q_pending2, fifo_count
    );

endinterface

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - circular result buffer with per-entry live bits, address kill and two pending CAM ports
module wb_fifo
    import wb_arbiter_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH,
    parameter int AW    = WB_AW,
    parameter int DW    = WB_DW,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push_i,
    input  logic [AW-1:0] push_waddr_i,
    input  logic [DW-1:0] push_wdata_i,
    input  logic [DW-1:0] push_pc_i,
    input  logic          pop_i,
    input  logic          kill_i,
    input  logic [AW-1:0] kill_addr_i,
    output logic          head_live_o,
    output logic [AW-1:0] head_waddr_o,
    output logic [DW-1:0] head_wdata_o,
    output logic [DW-1:0] head_pc_o,
    output logic [CW-1:0] count_o,
    input  logic [AW-1:0] q_addr1_i,
    input  logic [AW-1:0] q_addr2_i,
    output logic          q_hit1_o,
    output logic          q_hit2_o
);

    logic [DEPTH-1:0] live_q, live_d;
    logic [AW-1:0]    waddr_q [DEPTH];
    logic [DW-1:0]    wdata_q [DEPTH];
    logic [DW-1:0]    pc_q    [DEPTH];
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             hit1, hit2;

    // Live bits double as occupancy: a popped slot is cleared so the CAM sees only stored entries.
    always_comb begin
        live_d = live_q;
        if (kill_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (waddr_q[i] == kill_addr_i) live_d[i] = 1'b0;
            end
        end
        if (pop_i)  live_d[rd_ptr_q] = 1'b0;
        if (push_i) live_d[wr_ptr_q] = !(kill_i && (push_waddr_i == kill_addr_i));

        rd_ptr_d = rd_ptr_q + PW'(pop_i);
        wr_ptr_d = wr_ptr_q + PW'(push_i);
        count_d  = count_q;
        if (push_i && !pop_i)      count_d = count_q + 1'b1;
        else if (!push_i && pop_i) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            live_q   <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            live_q   <= live_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) begin
            waddr_q[wr_ptr_q] <= push_waddr_i;
            wdata_q[wr_ptr_q] <= push_wdata_i;
            pc_q[wr_ptr_q]    <= push_pc_i;
        end
    end

    always_comb begin
        hit1 = 1'b0;
        hit2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            hit1 = hit1 | (live_q[i] && (waddr_q[i] == q_addr1_i));
            hit2 = hit2 | (live_q[i] && (waddr_q[i] == q_addr2_i));
        end
    end

    assign q_hit1_o     = hit1 && (q_addr1_i != AW'(REG_ZERO));
    assign q_hit2_o     = hit2 && (q_addr2_i != AW'(REG_ZERO));
    assign head_live_o  = live_q[rd_ptr_q];
    assign head_waddr_o = waddr_q[rd_ptr_q];
    assign head_wdata_o = wdata_q[rd_ptr_q];
    assign head_pc_o    = pc_q[rd_ptr_q];
    assign count_o      = count_q;

endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - sole GPR write-port owner merging fixed-timing primary and queued secondary results
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH,
    parameter int AW    = WB_AW,
    parameter int DW    = WB_DW
) (
    input logic        clk,
    input logic        reset,
    wb_arbiter_if.slave bus
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [CW-1:0] count;
    logic          head_live;
    logic [AW-1:0] head_waddr;
    logic [DW-1:0] head_wdata;
    logic [DW-1:0] head_pc;
    logic          push, pop, kill, hit1, hit2;

    // Ready looks only at registered count, so a same-cycle pop never opens room for a push.
    assign bus.sec_ready = !reset && (count < CW'(DEPTH));
    assign push = bus.sec_valid && bus.sec_ready;
    assign pop  = !reset && !bus.pri_valid && (count != '0);
    assign kill = !reset && bus.pri_valid && (bus.pri_waddr != AW'(REG_ZERO));

    wb_fifo #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_fifo (
        .clk          (clk),
        .reset        (reset),
        .push_i       (push),
        .push_waddr_i (bus.sec_waddr),
        .push_wdata_i (bus.sec_wdata),
        .push_pc_i    (bus.sec_pc),
        .pop_i        (pop),
        .kill_i       (kill),
        .kill_addr_i  (bus.pri_waddr),
        .head_live_o  (head_live),
        .head_waddr_o (head_waddr),
        .head_wdata_o (head_wdata),
        .head_pc_o    (head_pc),
        .count_o      (count),
        .q_addr1_i    (bus.q_addr1),
        .q_addr2_i    (bus.q_addr2),
        .q_hit1_o     (hit1),
        .q_hit2_o     (hit2)
    );

    always_comb begin
        bus.grf_we    = 1'b0;
        bus.grf_waddr = '0;
        bus.grf_wdata = '0;
        bus.grf_pc    = '0;
        if (bus.pri_valid && !reset) begin
            bus.grf_we    = 1'b1;
            bus.grf_waddr = bus.pri_waddr;
            bus.grf_wdata = bus.pri_wdata;
            bus.grf_pc    = bus.pri_pc;
        end else if (pop && head_live) begin
            bus.grf_we    = 1'b1;
            bus.grf_waddr = head_waddr;
            bus.grf_wdata = head_wdata;
            bus.grf_pc    = head_pc;
        end
    end

    assign bus.q_pending1 = !reset && hit1;
    assign bus.q_pending2 = !reset && hit2;
    assign bus.fifo_count = count;

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - directed self-checking bench for wb_arbiter
module tb_wb_arbiter;

    logic clk = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;
    int   stray = 0;
    logic [31:0] gpr [32];

    always #5 clk = ~clk;

    wb_arbiter_if #(.DEPTH(4), .AW(5), .DW(32)) bus ();

    wb_arbiter #(.DEPTH(4), .AW(5), .DW(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always @(posedge clk) begin
        if (bus.grf_we) begin
            gpr[bus.grf_waddr] <= bus.grf_wdata;
            if (bus.grf_waddr >= 5'd20 && bus.grf_waddr <= 5'd22) stray <= stray + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pri(input logic v, input logic [4:0] a, input logic [31:0] d, input logic [31:0] pc);
        bus.pri_valid = v; bus.pri_waddr = a; bus.pri_wdata = d; bus.pri_pc = pc;
    endtask

    task automatic set_sec(input logic v, input logic [4:0] a, input logic [31:0] d, input logic [31:0] pc);
        bus.sec_valid = v; bus.sec_waddr = a; bus.sec_wdata = d; bus.sec_pc = pc;
    endtask

    task automatic check_grf(input string tag, input logic we, input logic [4:0] a, input logic [31:0] d);
        check({tag, "_we"},    bus.grf_we,    we);
        check({tag, "_waddr"}, bus.grf_waddr, a);
        check({tag, "_wdata"}, bus.grf_wdata, d);
    endtask

    initial begin
        reset = 1'b1;
        set_pri(0, 0, 0, 0);
        set_sec(0, 0, 0, 0);
        bus.q_addr1 = 5'd0;
        bus.q_addr2 = 5'd0;
        tick();
        tick();
        check("rst_we",    bus.grf_we, 0);
        check("rst_ready", bus.sec_ready, 0);
        check("rst_count", bus.fifo_count, 0);
        check("rst_pend",  bus.q_pending1, 0);
        reset = 1'b0;
        #1;
        check("idle_ready", bus.sec_ready, 1);

        // primary only
        set_pri(1, 5'd5, 32'h12345678, 32'h3000);
        #1;
        check_grf("pri", 1, 5'd5, 32'h12345678);
        check("pri_pc", bus.grf_pc, 32'h3000);
        tick();
        check("pri_count", bus.fifo_count, 0);

        // secondary drain
        set_pri(0, 0, 0, 0);
        set_sec(1, 5'd8, 32'hA, 32'h4000);
        bus.q_addr1 = 5'd8;
        #1;
        check("sec_nobypass", bus.grf_we, 0);
        check("sec_pend_push", bus.q_pending1, 0);
        tick();
        set_sec(0, 0, 0, 0);
        #1;
        check_grf("sec", 1, 5'd8, 32'hA);
        check("sec_pc", bus.grf_pc, 32'h4000);
        check("sec_pend", bus.q_pending1, 1);
        tick();
        check("sec_pend_after", bus.q_pending1, 0);
        check("sec_count_after", bus.fifo_count, 0);

        // full and backpressure
        set_pri(1, 5'd1, 32'h11, 32'h0);
        for (int i = 0; i < 4; i++) begin
            set_sec(1, 5'(10 + i), 32'(32'h100 + i), 32'(32'h5000 + i));
            #1;
            check("full_ready_fill", bus.sec_ready, 1);
            tick();
        end
        set_sec(1, 5'd14, 32'h200, 32'h5004);
        #1;
        check("full_count", bus.fifo_count, 4);
        check("full_ready", bus.sec_ready, 0);
        tick();
        check("full_held", bus.fifo_count, 4);
        set_pri(0, 0, 0, 0);
        #1;
        check_grf("drain0", 1, 5'd10, 32'h100);
        check("drain0_ready", bus.sec_ready, 0);
        tick();
        check("drain1_ready", bus.sec_ready, 1);
        check_grf("drain1", 1, 5'd11, 32'h101);
        tick();
        set_sec(0, 0, 0, 0);
        #1;
        check("drain2_count", bus.fifo_count, 3);
        check_grf("drain2", 1, 5'd12, 32'h102);
        tick();
        check_grf("drain3", 1, 5'd13, 32'h103);
        check("drain3_pc", bus.grf_pc, 32'h5003);
        tick();
        check_grf("drain4", 1, 5'd14, 32'h200);
        tick();
        check_grf("drain_empty", 0, 5'd0, 32'h0);
        check("drain_count", bus.fifo_count, 0);

        // WAW kill
        set_pri(1, 5'd1, 32'h11, 32'h0);
        set_sec(1, 5'd3, 32'h1, 32'h6000);
        tick();
        set_sec(1, 5'd4, 32'h2, 32'h6004);
        tick();
        set_sec(0, 0, 0, 0);
        set_pri(1, 5'd3, 32'h9, 32'h6100);
        bus.q_addr1 = 5'd3;
        bus.q_addr2 = 5'd4;
        #1;
        check_grf("waw_pri", 1, 5'd3, 32'h9);
        check("waw_pend_before", bus.q_pending1, 1);
        tick();
        set_pri(0, 0, 0, 0);
        #1;
        check("waw_pend_r3", bus.q_pending1, 0);
        check("waw_pend_r4", bus.q_pending2, 1);
        check("waw_count", bus.fifo_count, 2);
        check_grf("waw_dead", 0, 5'd0, 32'h0);
        tick();
        check_grf("waw_r4", 1, 5'd4, 32'h2);
        tick();
        check("waw_count_end", bus.fifo_count, 0);
        check("waw_r3_final", gpr[3], 32'h9);

        // same-cycle conflict
        set_pri(1, 5'd7, 32'h77, 32'h7000);
        set_sec(1, 5'd7, 32'h55, 32'h6ff0);
        bus.q_addr1 = 5'd7;
        #1;
        check_grf("conf_pri", 1, 5'd7, 32'h77);
        tick();
        set_pri(0, 0, 0, 0);
        set_sec(0, 0, 0, 0);
        #1;
        check("conf_pend", bus.q_pending1, 0);
        check("conf_count", bus.fifo_count, 1);
        check("conf_dead_we", bus.grf_we, 0);
        tick();
        check("conf_r7_final", gpr[7], 32'h77);

        // r0 neither kills nor shows pending
        set_pri(1, 5'd0, 32'hCD, 32'h0);
        set_sec(1, 5'd0, 32'hAB, 32'h0);
        bus.q_addr1 = 5'd0;
        #1;
        check_grf("r0_pri", 1, 5'd0, 32'hCD);
        tick();
        set_sec(0, 0, 0, 0);
        #1;
        check("r0_pend", bus.q_pending1, 0);
        check("r0_count", bus.fifo_count, 1);
        tick();
        set_pri(0, 0, 0, 0);
        #1;
        check_grf("r0_sec", 1, 5'd0, 32'hAB);
        tick();

        // reset mid-operation
        set_pri(1, 5'd1, 32'h11, 32'h0);
        for (int i = 0; i < 3; i++) begin
            set_sec(1, 5'(20 + i), 32'(32'h300 + i), 32'h0);
            tick();
        end
        set_sec(0, 0, 0, 0);
        set_pri(0, 0, 0, 0);
        bus.q_addr1 = 5'd20;
        #1;
        check("mid_count", bus.fifo_count, 3);
        check("mid_pend", bus.q_pending1, 1);
        reset = 1'b1;
        #1;
        check("mrst_we", bus.grf_we, 0);
        check("mrst_ready", bus.sec_ready, 0);
        check("mrst_pend", bus.q_pending1, 0);
        tick();
        check("mrst_count", bus.fifo_count, 0);
        check("mrst_we2", bus.grf_we, 0);
        reset = 1'b0;
        #1;
        check("post_ready", bus.sec_ready, 1);
        check("post_we", bus.grf_we, 0);
        check("post_pend", bus.q_pending1, 0);
        tick();
        tick();
        tick();
        check("post_stray", stray, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
